// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter for two shift requesters (a_*, b_*) driving a shared registered 4-bit shifter (sh_*), returning rsp_valid/rsp_id/rsp_result three cycles after grant
module shift_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic [3:0] a_data,
  input  logic [1:0] a_shift,
  input  logic       a_dir,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [3:0] b_data,
  input  logic [1:0] b_shift,
  input  logic       b_dir,
  output logic       b_ack,
  output logic [3:0] sh_data,
  output logic [1:0] sh_shift,
  output logic       sh_dir,
  input  logic [3:0] sh_result,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_result
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  state_t state, state_n;
  logic last_grant, id, grant, win;
  always_comb begin
    grant = state == IDLE && (a_req || b_req);
    win = (a_req && b_req) ? !last_grant : b_req;
    state_n = state == IDLE ? (grant ? ISSUE : IDLE) : state == ISSUE ? CAPTURE : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= 4'd0;
      sh_data <= 4'd0;
      sh_shift <= 2'd0;
      sh_dir <= 1'b0;
      id <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      a_ack <= grant && !win;
      b_ack <= grant && win;
      rsp_valid <= state == CAPTURE;
      if (grant) begin
        sh_data <= win ? b_data : a_data;
        sh_shift <= win ? b_shift : a_shift;
        sh_dir <= win ? b_dir : a_dir;
        id <= win;
        last_grant <= win;
      end
      if (state == CAPTURE) begin
        rsp_result <= sh_result;
        rsp_id <= id;
      end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed stimulus with a schedule-based reference model and literal checks
module tb_shift_arbiter;
  logic clk = 0, rst = 1, go = 0;
  logic a_req = 0, a_dir = 0, b_req = 0, b_dir = 0;
  logic [3:0] a_data = 0, b_data = 0;
  logic [1:0] a_shift = 0, b_shift = 0;
  logic a_ack, b_ack, sh_dir, rsp_valid, rsp_id;
  logic [3:0] sh_data, sh_result = 0, rsp_result;
  logic [1:0] sh_shift;
  int compared = 0, mismatched = 0;
  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_data(a_data), .a_shift(a_shift), .a_dir(a_dir), .a_ack(a_ack),
    .b_req(b_req), .b_data(b_data), .b_shift(b_shift), .b_dir(b_dir), .b_ack(b_ack),
    .sh_data(sh_data), .sh_shift(sh_shift), .sh_dir(sh_dir), .sh_result(sh_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] shf(logic [3:0] d, logic [1:0] s, logic r);
    return r ? d >> s : d << s;
  endfunction
  always @(posedge clk) sh_result <= shf(sh_data, sh_shift, sh_dir);
  typedef struct {int due; logic id; logic [3:0] res;} rsp_t;
  rsp_t pend[$];
  int cyc = 0, busy = 0;
  logic lg = 1, w;
  logic e_aack = 0, e_back = 0, e_rv = 0, e_id = 0, e_shdir = 0;
  logic [3:0] e_shd = 0, e_res = 0;
  logic [1:0] e_shs = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {e_aack, e_back, e_rv, e_id, e_shdir, e_shd, e_res, e_shs} = '0;
      lg = 1;
      busy = 0;
      pend.delete();
    end else begin
      e_aack = 0;
      e_back = 0;
      e_rv = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e_rv = 1;
        e_id = pend[0].id;
        e_res = pend[0].res;
        void'(pend.pop_front());
      end
      if (cyc >= busy && (a_req || b_req)) begin
        w = (a_req && b_req) ? !lg : b_req;
        lg = w;
        e_aack = !w;
        e_back = w;
        e_shd = w ? b_data : a_data;
        e_shs = w ? b_shift : a_shift;
        e_shdir = w ? b_dir : a_dir;
        pend.push_back('{cyc + 2, w, shf(e_shd, e_shs, e_shdir)});
        busy = cyc + 3;
      end
    end
    cyc++;
  end
  always @(negedge clk) if (go) begin
    compared++;
    if ({a_ack, b_ack, sh_data, sh_shift, sh_dir, rsp_valid, rsp_id, rsp_result} !==
        {e_aack, e_back, e_shd, e_shs, e_shdir, e_rv, e_id, e_res}) begin
      mismatched++;
      $display("FAIL model t=%0t: got ack=%b%b sh=%h/%0d/%b rsp=%b/%b/%h want ack=%b%b sh=%h/%0d/%b rsp=%b/%b/%h",
        $time, a_ack, b_ack, sh_data, sh_shift, sh_dir, rsp_valid, rsp_id, rsp_result,
        e_aack, e_back, e_shd, e_shs, e_shdir, e_rv, e_id, e_res);
    end
  end
  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    go = 1;
    step(1);
    chk("reset_ctl", {a_ack, b_ack, rsp_valid, rsp_id, rsp_result}, 8'h00);
    chk("reset_sh", {sh_data, sh_shift, sh_dir}, 8'h00);
    rst = 0;
    step(1);
    {a_req, a_data, a_shift, a_dir} = {1'b1, 4'b1011, 2'd1, 1'b0};
    step(1);
    chk("left_ack", {a_ack, b_ack}, 8'b10);
    chk("left_sh", {sh_data, sh_shift, sh_dir}, {1'b0, 4'b1011, 2'd1, 1'b0});
    a_req = 0;
    step(2);
    chk("left_rsp", {rsp_valid, rsp_id, rsp_result}, {2'b0, 1'b1, 1'b0, 4'b0110});
    step(1);
    rst = 1;
    step(1);
    rst = 0;
    step(1);
    {a_req, a_data, a_shift, a_dir} = {1'b1, 4'b0001, 2'd3, 1'b0};
    {b_req, b_data, b_shift, b_dir} = {1'b1, 4'b1111, 2'd2, 1'b1};
    step(1);
    chk("tie_ack_a", {a_ack, b_ack}, 8'b10);
    a_req = 0;
    step(2);
    chk("tie_rsp_a", {rsp_valid, rsp_id, rsp_result}, {2'b0, 1'b1, 1'b0, 4'b1000});
    step(1);
    chk("tie_ack_b", {a_ack, b_ack}, 8'b01);
    b_req = 0;
    step(2);
    chk("tie_rsp_b", {rsp_valid, rsp_id, rsp_result}, {2'b0, 1'b1, 1'b1, 4'b0011});
    step(1);
    {a_req, a_data, a_shift, a_dir} = {1'b1, 4'b0011, 2'd1, 1'b0};
    {b_req, b_data, b_shift, b_dir} = {1'b1, 4'b1100, 2'd1, 1'b1};
    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk($sformatf("rr_ack_%0d", i), {a_ack, b_ack},
          (i % 3 != 1) ? 8'b00 : ((i / 3) % 2 == 0) ? 8'b10 : 8'b01);
    end
    a_req = 0;
    b_req = 0;
    step(2);
    {b_req, b_data, b_shift, b_dir} = {1'b1, 4'b1000, 2'd3, 1'b1};
    step(1);
    chk("chg_ack", {a_ack, b_ack}, 8'b01);
    b_req = 0;
    step(1);
    b_data = 4'b0110;
    step(1);
    chk("chg_rsp", {rsp_valid, rsp_id, rsp_result}, {2'b0, 1'b1, 1'b1, 4'b0001});
    step(1);
    {a_req, a_data, a_shift, a_dir} = {1'b1, 4'b1100, 2'd1, 1'b1};
    step(1);
    a_req = 0;
    step(1);
    rst = 1;
    #1;
    chk("rst_mid_ctl", {a_ack, b_ack, rsp_valid, rsp_id, rsp_result}, 8'h00);
    chk("rst_mid_sh", {sh_data, sh_shift, sh_dir}, 8'h00);
    step(1);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("rst_no_rsp_%0d", i), {7'b0, rsp_valid}, 8'h00);
    end
    {a_req, a_data, a_shift, a_dir} = {1'b1, 4'b0101, 2'd0, 1'b1};
    step(1);
    a_req = 0;
    step(2);
    chk("post_rst_rsp", {rsp_valid, rsp_id, rsp_result}, {2'b0, 1'b1, 1'b0, 4'b0101});
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("idle_%0d", i), {a_ack, b_ack, rsp_valid, sh_data, sh_shift, sh_dir},
          {1'b0, 4'b0101, 2'd0, 1'b1});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
